// File: rtl/board_text_pkg.sv
// board_text_pkg: piece codes, ASCII constants and FSM encoding shared by board_text_stream.
package board_text_pkg;
  localparam logic [3:0] PC_EMPTY = 4'd0;
  localparam logic [3:0] PC_PAWN = 4'd1;
  localparam logic [3:0] PC_KNIGHT = 4'd2;
  localparam logic [3:0] PC_BISHOP = 4'd3;
  localparam logic [3:0] PC_ROOK = 4'd4;
  localparam logic [3:0] PC_QUEEN = 4'd5;
  localparam logic [3:0] PC_KING = 4'd6;
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CASE = 8'h20;
  typedef enum logic [3:0] {
    ST_IDLE, ST_SQUARE, ST_SEP, ST_EOL, ST_STATUS, ST_STATUS_EOL, ST_BLANK, ST_DONE
`ifdef BOARD_TEXT_LABELS_EN
    , ST_RANK_LBL, ST_RANK_SP, ST_FILE_PAD0, ST_FILE_PAD1, ST_FILE_LBL, ST_FILE_SP, ST_FILE_EOL
`endif
  } state_t;
  function automatic logic [7:0] status_char(input logic white, input logic black);
    return white ? (black ? "X" : "W") : (black ? "B" : "-");
  endfunction
endpackage

// File: rtl/board_text_stream_if.sv
// board_text_stream_if: render request, snapshot inputs and the valid/ready character stream.
interface board_text_stream_if #(
  parameter int PIECE_WIDTH = 4,
  parameter int FILES = 8,
  parameter int RANKS = 8
);
  localparam int BOARD_WIDTH = PIECE_WIDTH * FILES * RANKS;
  logic [BOARD_WIDTH-1:0] board;
  logic white_in_check, black_in_check, flip, start, busy, done;
  logic [7:0] char_out;
  logic char_valid, char_ready;
  modport master (
    output board, white_in_check, black_in_check, flip, start, char_ready,
    input busy, done, char_out, char_valid
  );
  modport slave (
    input board, white_in_check, black_in_check, flip, start, char_ready,
    output busy, done, char_out, char_valid
  );
endinterface

// File: rtl/board_text_stream_piece.sv
// piece_to_ascii: square code to glyph; bit 3 selects black, bits 2:0 the piece kind.
module piece_to_ascii
  import board_text_pkg::*;
#(
  parameter int PIECE_WIDTH = 4
) (
  input  logic [PIECE_WIDTH-1:0] code,
  output logic [7:0]             glyph
);
  logic [2:0] kind;
  logic [7:0] base;
  assign kind = code[2:0];
  always_comb begin
    base = kind == PC_PAWN[2:0]   ? "P" :
           kind == PC_KNIGHT[2:0] ? "N" :
           kind == PC_BISHOP[2:0] ? "B" :
           kind == PC_ROOK[2:0]   ? "R" :
           kind == PC_QUEEN[2:0]  ? "Q" :
           kind == PC_KING[2:0]   ? "K" : "?";
    glyph = code == PIECE_WIDTH'(PC_EMPTY) ? "." :
            ((code >> 4) != '0 || base == "?") ? "?" :
            code[3] ? (base | ASCII_CASE) : base;
  end
endmodule

// File: rtl/board_text_stream.sv
// board_text_stream: renders a board snapshot as ASCII text over a valid/ready byte stream.
// Define BOARD_TEXT_LABELS_EN to add rank digits and a trailing file-letter line.
module board_text_stream
  import board_text_pkg::*;
#(
  parameter int PIECE_WIDTH = 4,
  parameter int FILES = 8,
  parameter int RANKS = 8
) (
  input logic clk,
  input logic reset,
  board_text_stream_if.slave bus
);
  localparam int BOARD_WIDTH = PIECE_WIDTH * FILES * RANKS;
  localparam int FW = FILES > 1 ? $clog2(FILES) : 1;
  localparam int RW = RANKS > 1 ? $clog2(RANKS) : 1;
  localparam int SW = BOARD_WIDTH > 1 ? $clog2(BOARD_WIDTH) : 1;
  localparam logic [FW-1:0] FILE_LAST = FW'(FILES - 1);
  localparam logic [RW-1:0] RANK_LAST = RW'(RANKS - 1);
`ifdef BOARD_TEXT_LABELS_EN
  localparam state_t LINE_START = ST_RANK_LBL;
  localparam state_t BOARD_END = ST_FILE_PAD0;
`else
  localparam state_t LINE_START = ST_SQUARE;
  localparam state_t BOARD_END = ST_STATUS;
`endif
  state_t state, state_n;
  logic [FW-1:0] file_cnt, file_n, file_idx;
  logic [RW-1:0] rank_cnt, rank_n, rank_idx;
  logic [BOARD_WIDTH-1:0] board_q;
  logic white_q, black_q, flip_q, xfer;
  logic [SW-1:0] bit_idx;
  logic [7:0] glyph;
  assign xfer = bus.char_valid && bus.char_ready;
  // counters always run 0..N-1; flip only changes which square they address
  assign file_idx = flip_q ? FILE_LAST - file_cnt : file_cnt;
  assign rank_idx = flip_q ? rank_cnt : RANK_LAST - rank_cnt;
  assign bit_idx = SW'((int'(rank_idx) * FILES + int'(file_idx)) * PIECE_WIDTH);
  piece_to_ascii #(.PIECE_WIDTH(PIECE_WIDTH)) u_glyph (
    .code (board_q[bit_idx +: PIECE_WIDTH]),
    .glyph(glyph)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      file_cnt <= '0;
      rank_cnt <= '0;
    end else begin
      state <= state_n;
      file_cnt <= file_n;
      rank_cnt <= rank_n;
    end
    if (!reset && state == ST_IDLE && bus.start) begin
      board_q <= bus.board;
      white_q <= bus.white_in_check;
      black_q <= bus.black_in_check;
      flip_q <= bus.flip;
    end
  end
  always_comb begin
    state_n = state;
    file_n = file_cnt;
    rank_n = rank_cnt;
    bus.char_out = ASCII_NUL;
    bus.done = 1'b0;
    case (state)
      ST_IDLE: begin
        file_n = '0;
        rank_n = '0;
        state_n = bus.start ? LINE_START : ST_IDLE;
      end
`ifdef BOARD_TEXT_LABELS_EN
      ST_RANK_LBL: begin
        bus.char_out = "1" + 8'(rank_idx);
        state_n = xfer ? ST_RANK_SP : state;
      end
      ST_RANK_SP: begin
        bus.char_out = ASCII_SP;
        state_n = xfer ? ST_SQUARE : state;
      end
      ST_FILE_PAD0: begin
        bus.char_out = ASCII_SP;
        state_n = xfer ? ST_FILE_PAD1 : state;
      end
      ST_FILE_PAD1: begin
        bus.char_out = ASCII_SP;
        state_n = xfer ? ST_FILE_LBL : state;
      end
      ST_FILE_LBL: begin
        bus.char_out = "a" + 8'(file_idx);
        state_n = xfer ? ST_FILE_SP : state;
      end
      ST_FILE_SP: begin
        bus.char_out = ASCII_SP;
        if (xfer) begin
          state_n = file_cnt == FILE_LAST ? ST_FILE_EOL : ST_FILE_LBL;
          if (file_cnt != FILE_LAST) file_n = file_cnt + 1'b1;
        end
      end
      ST_FILE_EOL: begin
        bus.char_out = ASCII_LF;
        state_n = xfer ? ST_STATUS : state;
      end
`endif
      ST_SQUARE: begin
        bus.char_out = glyph;
        state_n = xfer ? ST_SEP : state;
      end
      ST_SEP: begin
        bus.char_out = ASCII_SP;
        if (xfer) begin
          state_n = file_cnt == FILE_LAST ? ST_EOL : ST_SQUARE;
          if (file_cnt != FILE_LAST) file_n = file_cnt + 1'b1;
        end
      end
      ST_EOL: begin
        bus.char_out = ASCII_LF;
        if (xfer) begin
          file_n = '0;
          state_n = rank_cnt == RANK_LAST ? BOARD_END : LINE_START;
          if (rank_cnt != RANK_LAST) rank_n = rank_cnt + 1'b1;
        end
      end
      ST_STATUS: begin
        bus.char_out = status_char(white_q, black_q);
        state_n = xfer ? ST_STATUS_EOL : state;
      end
      ST_STATUS_EOL: begin
        bus.char_out = ASCII_LF;
        state_n = xfer ? ST_BLANK : state;
      end
      ST_BLANK: begin
        bus.char_out = ASCII_LF;
        state_n = xfer ? ST_DONE : state;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    bus.busy = state != ST_IDLE && state != ST_DONE;
    bus.char_valid = bus.busy;
  end
endmodule

// File: tb/tb_board_text_stream.sv
// tb_board_text_stream: random-stall stream checks of board_text_stream against a text model.
module tb_board_text_stream;
  localparam int PW = 4, FILES = 8, RANKS = 8, BW = PW * FILES * RANKS;
`ifdef BOARD_TEXT_LABELS_EN
  localparam int TOTAL = RANKS * (2 * FILES + 3) + 2 * FILES + 3 + 3;
`else
  localparam int TOTAL = RANKS * (2 * FILES + 1) + 3;
`endif
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  board_text_stream_if #(.PIECE_WIDTH(PW), .FILES(FILES), .RANKS(RANKS)) bus ();
  board_text_stream #(.PIECE_WIDTH(PW), .FILES(FILES), .RANKS(RANKS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_assert = 0, n_fail = 0;
  byte unsigned exp_q[$], got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic byte unsigned glyph(input logic [3:0] c);
    string w = "PNBRQK", b = "pnbrqk";
    if (c == 0) return ".";
    if (c >= 1 && c <= 6) return w[int'(c) - 1];
    if (c >= 9 && c <= 14) return b[int'(c) - 9];
    return "?";
  endfunction

  // expected text built directly from the rendering rules
  function automatic void build(input logic [BW-1:0] bd, input logic w, input logic b, input logic fl);
    int r, f;
    exp_q.delete();
    for (int i = 0; i < RANKS; i++) begin
      r = fl ? i : RANKS - 1 - i;
`ifdef BOARD_TEXT_LABELS_EN
      exp_q.push_back(8'(49 + r));
      exp_q.push_back(8'h20);
`endif
      for (int j = 0; j < FILES; j++) begin
        f = fl ? FILES - 1 - j : j;
        exp_q.push_back(glyph(bd[(r * FILES + f) * PW +: PW]));
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0A);
    end
`ifdef BOARD_TEXT_LABELS_EN
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h20);
    for (int j = 0; j < FILES; j++) begin
      exp_q.push_back(8'(97 + (fl ? FILES - 1 - j : j)));
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0A);
`endif
    exp_q.push_back(w && b ? "X" : w ? "W" : b ? "B" : "-");
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic logic [BW-1:0] initial_board();
    logic [BW-1:0] bd = '0;
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int f = 0; f < 8; f++) begin
      bd[f * 4 +: 4] = 4'(back[f]);
      bd[(8 + f) * 4 +: 4] = 4'd1;
      bd[(48 + f) * 4 +: 4] = 4'd9;
      bd[(56 + f) * 4 +: 4] = 4'(back[f] + 8);
    end
    return bd;
  endfunction

  function automatic logic [BW-1:0] random_board();
    logic [BW-1:0] bd;
    for (int i = 0; i < FILES * RANKS; i++) bd[i * PW +: PW] = 4'($urandom_range(0, 15));
    return bd;
  endfunction

  task automatic check_str(input string tag, input int off, input string s);
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s:%0d", tag, i), (off + i < got_q.size()) ? got_q[off + i] : 8'h00, s[i]);
  endtask

  task automatic compare_stream(input string name);
    check({name, ":count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s:c%0d", name, i), (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
  endtask

  task automatic run(input bit rand_ready, input int abort_at, input string name);
    int n = 0, last = -10;
    bit stall = 0, ended = 0, r;
    byte unsigned held = 0;
    got_q.delete();
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    check({name, ":busy"}, bus.busy, 1);
    check({name, ":first_valid"}, bus.char_valid, 1);
    bus.board = ~bus.board;
    bus.white_in_check = ~bus.white_in_check;
    bus.black_in_check = ~bus.black_in_check;
    bus.flip = ~bus.flip;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      if (stall) begin
        check({name, ":hold_valid"}, bus.char_valid, 1);
        check({name, ":hold_char"}, bus.char_out, held);
      end
      if (bus.done) begin
        check({name, ":count_at_done"}, n, TOTAL);
        check({name, ":done_after_last"}, cyc - last, 1);
        check({name, ":done_busy"}, bus.busy, 0);
        ended = 1;
      end else if (n == abort_at) begin
        reset = 1;
        bus.char_ready = 0;
        @(negedge clk);
        reset = 0;
        check({name, ":rst_busy"}, bus.busy, 0);
        check({name, ":rst_valid"}, bus.char_valid, 0);
        check({name, ":rst_done"}, bus.done, 0);
        check({name, ":rst_char"}, bus.char_out, 0);
        return;
      end else begin
        r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.start = (n == 10);
        bus.char_ready = r;
        if (bus.char_valid && r) begin
          got_q.push_back(bus.char_out);
          n++;
          last = cyc;
        end
        stall = bus.char_valid && !r;
        held = bus.char_out;
        @(negedge clk);
      end
    end
    bus.start = 0;
    check({name, ":terminated"}, ended, 1);
    @(negedge clk);
    check({name, ":idle_after"}, bus.busy, 0);
    check({name, ":done_pulse"}, bus.done, 0);
  endtask

  task automatic setup(input logic [BW-1:0] bd, input logic w, input logic b, input logic fl);
    bus.board = bd;
    bus.white_in_check = w;
    bus.black_in_check = b;
    bus.flip = fl;
    build(bd, w, b, fl);
  endtask

  initial begin
    logic [BW-1:0] bd;
    bus.board = '0;
    bus.white_in_check = 0;
    bus.black_in_check = 0;
    bus.flip = 0;
    bus.start = 0;
    bus.char_ready = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_valid", bus.char_valid, 0);
    check("reset_char", bus.char_out, 0);
    reset = 0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    reset = 1;
    bus.start = 1;
    @(negedge clk);
    reset = 0;
    bus.start = 0;
    check("rst_over_start", bus.busy, 0);
    @(negedge clk);
    check("rst_over_start2", bus.char_valid, 0);

    setup(initial_board(), 0, 0, 0);
    run(0, -1, "init");
    compare_stream("init");
`ifdef BOARD_TEXT_LABELS_EN
    check_str("init_head", 0, "8 r n");
    check_str("file_labels", RANKS * (2 * FILES + 3), "  a b c d e f g h \n");
`else
    check_str("init_head", 0, "r n b q k b n r \n");
`endif
    check_str("init_tail", TOTAL - 3, "-\n\n");

    setup(initial_board(), 0, 0, 1);
    run(0, -1, "flip");
    compare_stream("flip");
`ifdef BOARD_TEXT_LABELS_EN
    check_str("flip_head", 0, "1 R N B K Q B N R \n");
    check_str("flip_last", (RANKS - 1) * (2 * FILES + 3), "8 r n b k q b n r \n");
    check_str("flip_labels", RANKS * (2 * FILES + 3), "  h g f e d c b a \n");
`else
    check_str("flip_head", 0, "R N B K Q B N R \n");
    check_str("flip_last", TOTAL - 3 - (2 * FILES + 1), "r n b k q b n r \n");
`endif

    setup(initial_board(), 0, 0, 0);
    run(1, -1, "stall");
    compare_stream("stall");

    setup(random_board(), 1, 0, 0);
    run(1, -1, "white");
    compare_stream("white");
    check_str("white_status", TOTAL - 3, "W");
    setup(random_board(), 1, 1, 1);
    run(1, -1, "both");
    compare_stream("both");
    check_str("both_status", TOTAL - 3, "X");
    setup(random_board(), 0, 1, 0);
    run(1, -1, "black");
    compare_stream("black");

    setup(initial_board(), 0, 0, 0);
    run(0, 40, "abort");
    setup(initial_board(), 0, 0, 0);
    run(0, -1, "restart");
    compare_stream("restart");

    for (int k = 0; k < 3; k++) begin
      bd = random_board();
      setup(bd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run(1, -1, $sformatf("rnd%0d", k));
      compare_stream($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
